// File: rtl/fpu_koa_pkg.sv
// Shared types and defaults for the Karatsuba multiplier sequencer.
package fpu_koa_pkg;

    localparam int unsigned SW_DEF  = 24;
    localparam int unsigned LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Settle counter must hold LAT-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ties go to the requester not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/koa_mult_sched.sv
// Sequences one shared Karatsuba multiplier between the FP-multiply and div/sqrt paths.
module koa_mult_sched
    import fpu_koa_pkg::*;
#(
    parameter int unsigned SW  = SW_DEF,
    parameter int unsigned LAT = LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [SW-1:0]   req0_a_i,
    input  logic [SW-1:0]   req0_b_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [SW-1:0]   req1_a_i,
    input  logic [SW-1:0]   req1_b_i,
    output logic            rsp0_valid_o,
    output logic            rsp1_valid_o,
    input  logic            rsp_ready_i,
    output logic [2*SW-1:0] rsp_data_o,
    output logic            busy_o,
    output logic [SW-1:0]   koa_a_o,
    output logic [SW-1:0]   koa_b_o,
    output logic            koa_load_o,
    input  logic [2*SW-1:0] koa_result_i
);

    localparam int unsigned CW = cnt_width(LAT);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          owner;
    logic [1:0]    grant;
    logic          accept;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid_i, req0_valid_i}),
        .accept (accept),
        .grant  (grant)
    );

    // Requests are only taken in IDLE; ready is held low while reset is asserted.
    assign accept       = (state == IDLE) && (grant != 2'b00);
    assign req0_ready_o = rst && (state == IDLE) && grant[0];
    assign req1_ready_o = rst && (state == IDLE) && grant[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        koa_load_o   = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        rsp_data_o   = '0;
        busy_o       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CALC;
                    cnt_nx   = CW'(LAT - 1);
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nx = LOAD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            LOAD: begin
                koa_load_o = 1'b1;
                state_nx   = DONE;
            end
            DONE: begin
                rsp0_valid_o = !owner;
                rsp1_valid_o = owner;
                rsp_data_o   = koa_result_i;
                if (rsp_ready_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands stay on the multiplier inputs for the whole operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= 1'b0;
            koa_a_o <= '0;
            koa_b_o <= '0;
        end else if (accept) begin
            owner   <= grant[1];
            koa_a_o <= grant[1] ? req1_a_i : req0_a_i;
            koa_b_o <= grant[1] ? req1_b_i : req0_b_i;
        end
    end

endmodule

// File: tb/tb_koa_mult_sched.sv
// Bench for koa_mult_sched: transaction-level model plus directed scenarios.
module tb_koa_mult_sched;
    import fpu_koa_pkg::*;

    localparam int unsigned SW  = SW_DEF;
    localparam int unsigned LAT = LAT_DEF;
    localparam int unsigned PW  = 2 * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [SW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp_ready = 1'b1;
    logic [PW-1:0] rsp_data;
    logic          busy;
    logic [SW-1:0] koa_a, koa_b;
    logic          koa_load;
    logic [PW-1:0] koa_result = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    koa_mult_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .rsp0_valid_o (rsp0_valid),
        .rsp1_valid_o (rsp1_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy),
        .koa_a_o      (koa_a),
        .koa_b_o      (koa_b),
        .koa_load_o   (koa_load),
        .koa_result_i (koa_result)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [PW-1:0] x, y;
        x = PW'(a);
        y = PW'(b);
        return x * y;
    endfunction

    function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 2'b01 : 2'b10;
        return {v1, v0};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Multiplier result register driven by the strobe.
    always @(posedge clk) begin
        if (koa_load) koa_result <= mul(koa_a, koa_b);
    end

    // Model: m_age counts cycles since acceptance (-1 when idle).
    int            m_age   = -1;
    logic          m_last  = 1'b1;
    logic          m_owner = 1'b0;
    logic [SW-1:0] m_a = '0, m_b = '0;

    always @(posedge clk or negedge rst) begin
        logic [1:0] g;
        if (!rst) begin
            m_age  = -1;
            m_last = 1'b1;
        end else if (m_age < 0) begin
            g = exp_grant(req0_valid, req1_valid, m_last);
            if (g != 2'b00) begin
                m_age   = 1;
                m_owner = g[1];
                m_last  = g[1];
                m_a     = g[1] ? req1_a : req0_a;
                m_b     = g[1] ? req1_b : req0_b;
            end
        end else if (m_age < int'(LAT) + 2) begin
            m_age++;
        end else if (rsp_ready) begin
            m_age = -1;
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        logic       idle, done;
        if (chk_en) begin
            g    = exp_grant(req0_valid, req1_valid, m_last);
            idle = (m_age < 0);
            done = rst && (m_age >= int'(LAT) + 2);
            check("req0_ready", 64'(req0_ready), 64'(rst && idle && g[0]));
            check("req1_ready", 64'(req1_ready), 64'(rst && idle && g[1]));
            check("busy", 64'(busy), 64'(rst && !idle));
            check("koa_load", 64'(koa_load), 64'(rst && m_age == int'(LAT) + 1));
            check("rsp0_valid", 64'(rsp0_valid), 64'(done && !m_owner));
            check("rsp1_valid", 64'(rsp1_valid), 64'(done && m_owner));
            if (!rst) begin
                check("rsp_data_rst", 64'(rsp_data), 64'(0));
                check("koa_a_rst", 64'(koa_a), 64'(0));
                check("koa_b_rst", 64'(koa_b), 64'(0));
            end else begin
                if (done) check("rsp_data", 64'(rsp_data), 64'(mul(m_a, m_b)));
                if (!idle) begin
                    check("koa_a", 64'(koa_a), 64'(m_a));
                    check("koa_b", 64'(koa_b), 64'(m_b));
                end
            end
        end
    end

    // Waits for the requester's ready, then returns just after the accepting edge.
    task automatic wait_ready(input int r);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // Called just after an accepting edge; k counts cycles from acceptance.
    task automatic wait_rsp(output int who, output logic [PW-1:0] data,
                            output int lat, output int load_k);
        who = -1; lat = -1; load_k = -1; data = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (koa_load && load_k < 0) load_k = k;
            if (rsp0_valid || rsp1_valid) begin
                who  = rsp1_valid ? 1 : 0;
                data = rsp_data;
                lat  = k;
                break;
            end
        end
        check("rsp_timeout", 64'(who >= 0), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            who, lat, load_k, n, bad;
        logic [PW-1:0] data;
        logic [PW-1:0] lit;
        logic [5:0]    seq;

        // Reset held with random inputs
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (4) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            rsp_ready  = 1'($urandom);
            req0_a = SW'($urandom); req0_b = SW'($urandom);
            req1_a = SW'($urandom); req1_b = SW'($urandom);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check("busy_after_rst", 64'(busy), 64'(0));
        req1_valid = 1'b1;
        #1 check("ready1_follows", 64'(req1_ready), 64'(1));
        req1_valid = 1'b0;
        #1 check("ready1_drops", 64'(req1_ready), 64'(0));
        req0_valid = 1'b1;
        #1 check("ready0_follows", 64'(req0_ready), 64'(1));
        req0_valid = 1'b0;

        // Max operands, latency and load strobe position
        @(posedge clk); #1;
        req0_a = 24'hFFFFFF; req0_b = 24'hFFFFFF; req0_valid = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        wait_rsp(who, data, lat, load_k);
        lit = 48'hFFFFFE000001;
        check("t2_who", 64'(who), 64'(0));
        check("t2_data", 64'(data), 64'(lit));
        check("t2_latency", 64'(lat), 64'(LAT + 2));
        check("t2_load_k", 64'(load_k), 64'(LAT + 1));
        @(negedge clk);
        check("t2_one_cycle", 64'(rsp0_valid), 64'(0));

        // Simultaneous requests
        @(posedge clk); #1;
        req0_a = 24'd3; req0_b = 24'd5; req1_a = 24'd7; req1_b = 24'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        wait_rsp(who, data, lat, load_k);
        check("t3_first_who", 64'(who), 64'(0));
        check("t3_first_data", 64'(data), 64'(15));
        wait_ready(1);
        req1_valid = 1'b0;
        wait_rsp(who, data, lat, load_k);
        check("t3_second_who", 64'(who), 64'(1));
        check("t3_second_data", 64'(data), 64'(63));

        // Sustained contention alternates grants
        @(posedge clk); #1;
        req0_a = 24'd2; req0_b = 24'd3; req1_a = 24'd4; req1_b = 24'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0; seq = '0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            @(negedge clk);
            if (req0_ready) begin
                n++;
            end else if (req1_ready) begin
                seq[n] = 1'b1;
                n++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t4_count", 64'(n), 64'(6));
        check("t4_sequence", 64'(seq), 64'(6'b101010));
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        check("t4_drain", 64'(busy), 64'(0));

        // Response back-pressure
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_a = 24'd1234; req0_b = 24'd5678; req0_valid = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        req1_a = 24'd6; req1_b = 24'd7; req1_valid = 1'b1;
        wait_rsp(who, data, lat, load_k);
        check("t5_data", 64'(data), 64'(7006652));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(rsp0_valid), 64'(1));
            check("t5_hold_data", 64'(rsp_data), 64'(7006652));
            check("t5_hold_ready1", 64'(req1_ready), 64'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_idle", 64'(busy), 64'(0));
        check("t5_ready1", 64'(req1_ready), 64'(1));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(who, data, lat, load_k);
        check("t5_req1_who", 64'(who), 64'(1));
        check("t5_req1_data", 64'(data), 64'(42));

        // Reset during CALC aborts the operation
        @(posedge clk); #1;
        req0_a = 24'd100; req0_b = 24'd200; req0_valid = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (koa_load || rsp0_valid || rsp1_valid || busy) bad++;
        end
        check("t6_aborted", 64'(bad), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        req0_a = 24'd11; req0_b = 24'd13; req1_a = 24'd2; req1_b = 24'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        wait_rsp(who, data, lat, load_k);
        check("t6_who", 64'(who), 64'(0));
        check("t6_data", 64'(data), 64'(143));
        check("t6_latency", 64'(lat), 64'(LAT + 2));
        wait_ready(1);
        req1_valid = 1'b0;
        wait_rsp(who, data, lat, load_k);
        check("t6_req1_data", 64'(data), 64'(4));

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
